// File: rtl/alu_drv.sv
// Request/response driver for an external ALU32: registers operands, holds them stable and
// captures Sum/Cout ALU_LAT+1 cycles after accept. Result checking is enabled by ALU_DRV_CHECK_EN.
module alu_drv #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_sel,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_cin,
    input  logic [31:0] req_exp_sum,
    input  logic        req_exp_cout,
    output logic [2:0]  alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    input  logic [31:0] alu_sum,
    input  logic        alu_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_mismatch,
    output logic [15:0] err_count,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

    // The counter value seen on the capture edge equals ALU_LAT (it starts at 0 on the first HOLD cycle).
    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        accept;
    logic        capture;

    assign accept  = (state_q == IDLE) && req_valid;
    assign capture = (state_q == HOLD) && (cnt_q == LAT_LAST);

    // NOTE: every next-state signal is given its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                    cnt_d   = 3'd0;
                    sel_d   = req_sel;
                    a_d     = req_a;
                    b_d     = req_b;
                    cin_d   = req_cin;
                end
            end
            HOLD: begin
                if (capture) begin
                    state_d = RESP;
                    sum_d   = alu_sum;
                    cout_d  = alu_cout;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous and wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            sel_q   <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            cin_q   <= 1'b0;
            sum_q   <= 32'd0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign alu_sel   = sel_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_cin   = cin_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;

`ifdef ALU_DRV_CHECK_EN
    logic [31:0] exp_sum_q, exp_sum_d;
    logic        exp_cout_q, exp_cout_d;
    logic        mis_q, mis_d;
    logic [15:0] err_q, err_d;
    logic        diff;

    assign diff = (alu_sum != exp_sum_q) || (alu_cout != exp_cout_q);

    always_comb begin
        exp_sum_d  = exp_sum_q;
        exp_cout_d = exp_cout_q;
        mis_d      = mis_q;
        err_d      = err_q;
        if (accept) begin
            exp_sum_d  = req_exp_sum;
            exp_cout_d = req_exp_cout;
        end
        if (capture) begin
            mis_d = diff;
            if (diff && (err_q != 16'hFFFF)) begin
                err_d = err_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_sum_q  <= 32'd0;
            exp_cout_q <= 1'b0;
            mis_q      <= 1'b0;
            err_q      <= 16'd0;
        end else begin
            exp_sum_q  <= exp_sum_d;
            exp_cout_q <= exp_cout_d;
            mis_q      <= mis_d;
            err_q      <= err_d;
        end
    end

    assign rsp_mismatch = mis_q;
    assign err_count    = err_q;
`else
    // Expected values are not consumed when checking is compiled out.
    logic unused_exp;
    assign unused_exp   = ^{req_exp_sum, req_exp_cout};
    assign rsp_mismatch = 1'b0;
    assign err_count    = 16'd0;
`endif

endmodule

// File: tb/tb_alu_drv.sv
// Bench for alu_drv: ALU32 stand-in, transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_drv;

    localparam int unsigned ALU_LAT = 1;
`ifdef ALU_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sel;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_cin;
    logic [31:0] req_exp_sum;
    logic        req_exp_cout;
    logic [2:0]  alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_cin;
    logic [31:0] alu_sum;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_mismatch;
    logic [15:0] err_count;
    logic        busy;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    bit force_now = 1'b0;

    alu_drv #(.ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .req_exp_sum(req_exp_sum), .req_exp_cout(req_exp_cout),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_sum(alu_sum), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_mismatch(rsp_mismatch), .err_count(err_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // ALU32 stand-in: {cout, sum}
    function automatic logic [32:0] alu_fn(input logic [2:0] s, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
        case (s)
            3'b000:  alu_fn = {1'b0, a} + {1'b0, b} + {32'd0, c};
            3'b001:  alu_fn = {1'b0, a} + {1'b0, ~b} + {32'd0, c};
            3'b100:  alu_fn = {1'b0, a & b};
            3'b101:  alu_fn = {1'b0, a | b};
            3'b110:  alu_fn = {1'b0, a ^ b};
            default: alu_fn = {1'b0, a};
        endcase
    endfunction

    logic [32:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_sel, alu_a, alu_b, alu_cin);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign {alu_cout, alu_sum} = alu_pipe[ALU_LAT-1];

    // Transaction-level reference: one op in flight, result due ALU_LAT+1 edges after accept.
    bit          m_busy, m_valid;
    int          m_wait;
    logic [2:0]  m_sel;
    logic [31:0] m_a, m_b, m_xs, m_sum;
    logic        m_cin, m_xc, m_cout, m_mis;
    logic [15:0] m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_valid = 0; m_wait = 0;
            m_sel = 0; m_a = 0; m_b = 0; m_cin = 0; m_xs = 0; m_xc = 0;
            m_sum = 0; m_cout = 0; m_mis = 0; m_err = 0;
        end else if (force_now) begin
            m_err = 16'hFFFE;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1; m_wait = ALU_LAT + 1;
                m_sel = req_sel; m_a = req_a; m_b = req_b; m_cin = req_cin;
                m_xs = req_exp_sum; m_xc = req_exp_cout;
            end
        end else if (!m_valid) begin
            m_wait--;
            if (m_wait == 0) begin
                {m_cout, m_sum} = alu_fn(m_sel, m_a, m_b, m_cin);
                m_mis = CHK && ((m_sum != m_xs) || (m_cout != m_xc));
                if (m_mis && m_err != 16'hFFFF) m_err = m_err + 16'd1;
                m_valid = 1;
            end
        end else if (rsp_ready) begin
            m_valid = 0; m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("req_ready", req_ready, !m_busy);
            check("busy", busy, m_busy);
            check("rsp_valid", rsp_valid, m_valid);
            check("alu_sel", alu_sel, m_sel);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_cin", alu_cin, m_cin);
            check("rsp_sum", rsp_sum, m_sum);
            check("rsp_cout", rsp_cout, m_cout);
            check("rsp_mismatch", rsp_mismatch, m_mis);
            check("err_count", err_count, m_err);
        end
    end

    task automatic send(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] xs, input logic xc);
        bit got;
        @(posedge clk); #1;
        req_sel = sel; req_a = a; req_b = b; req_cin = cin;
        req_exp_sum = xs; req_exp_cout = xc; req_valid = 1'b1;
        got = 0;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (req_ready) begin got = 1; break; end
        end
        check("accept_timeout", got, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] xs, input logic xc,
                          output logic [31:0] s, output logic c, output logic mis,
                          output int lat, output int bcnt);
        send(sel, a, b, cin, xs, xc);
        lat = -1; bcnt = 0; s = '0; c = 1'b0; mis = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (rsp_valid && lat < 0) begin
                lat = n - 1; s = rsp_sum; c = rsp_cout; mis = rsp_mismatch;
            end
            if (!busy) break;
        end
        check("rsp_timeout", lat >= 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic        c, mis;
        int          lat, bcnt;
        bit          got;

        rst = 1'b1; req_valid = 1'b0; req_sel = '0; req_a = '0; req_b = '0; req_cin = 1'b0;
        req_exp_sum = '0; req_exp_cout = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_err", err_count, 0);

        // 1 + 1: two-cycle latency, busy for three cycles
        run_op(3'b000, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, s, c, mis, lat, bcnt);
        check("add_sum", s, 32'd2);
        check("add_cout", c, 0);
        check("add_latency", lat, 2);
        check("add_busy_cycles", bcnt, 3);
        check("add_mismatch", mis, 0);

        // wrap-around carry captured verbatim
        run_op(3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, s, c, mis, lat, bcnt);
        check("wrap_sum", s, 32'd0);
        check("wrap_cout", c, 1);

        // back-pressure: response held, new request ignored until after the rsp handshake
        rsp_ready = 1'b0;
        send(3'b000, 32'd10, 32'd20, 1'b1, 32'd31, 1'b0);
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; break; end
        end
        check("bp_valid_timeout", got, 1);
        req_sel = 3'b001; req_a = 32'd100; req_b = 32'd1; req_cin = 1'b1;
        req_exp_sum = 32'd99; req_exp_cout = 1'b1; req_valid = 1'b1;
        repeat (5) begin
            check("bp_hold_sum", rsp_sum, 32'd31);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_alu_a", alu_a, 32'd10);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_after_hs_ready", req_ready, 1);
        check("bp_after_hs_alu_a", alu_a, 32'd10);
        @(negedge clk);
        check("bp_second_alu_a", alu_a, 32'd100);
        check("bp_second_alu_sel", alu_sel, 3'b001);
        check("bp_second_busy", busy, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; break; end
        end
        check("bp_second_timeout", got, 1);
        check("sub_sum", rsp_sum, 32'd99);
        check("sub_cout", rsp_cout, 1);
        @(negedge clk);

        // expectation mismatch, then a correct one
        run_op(3'b100, 32'd5, 32'd3, 1'b0, 32'd5, 1'b0, s, c, mis, lat, bcnt);
        check("and_sum", s, 32'd1);
        check("bad_exp_mismatch", mis, CHK ? 1 : 0);
        check("bad_exp_err", err_count, CHK ? 16'd1 : 16'd0);
        run_op(3'b100, 32'd5, 32'd3, 1'b0, 32'd1, 1'b0, s, c, mis, lat, bcnt);
        check("good_exp_mismatch", mis, 0);
        check("good_exp_err", err_count, CHK ? 16'd1 : 16'd0);

        // reset one cycle into HOLD abandons the operation
        send(3'b000, 32'd7, 32'd8, 1'b0, 32'd15, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("hold_rst_ready", req_ready, 1);
        check("hold_rst_busy", busy, 0);
        check("hold_rst_alu_a", alu_a, 0);
        check("hold_rst_alu_b", alu_b, 0);
        check("hold_rst_err", err_count, 0);
        repeat (6) begin
            @(negedge clk);
            check("hold_rst_no_rsp", rsp_valid, 0);
        end

`ifdef ALU_DRV_CHECK_EN
        // saturation of the mismatch counter
        @(posedge clk); #1 force_now = 1'b1;
        @(posedge clk); #1 force dut.err_q = 16'hFFFE;
        #1 release dut.err_q;
        force_now = 1'b0;
        @(negedge clk);
        check("sat_seed", err_count, 16'hFFFE);
        run_op(3'b100, 32'd5, 32'd3, 1'b0, 32'd5, 1'b0, s, c, mis, lat, bcnt);
        check("sat_first", err_count, 16'hFFFF);
        check("sat_first_mis", mis, 1);
        run_op(3'b100, 32'd5, 32'd3, 1'b0, 32'd5, 1'b0, s, c, mis, lat, bcnt);
        check("sat_second", err_count, 16'hFFFF);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_drv.md
ALU_DRV -- requirements
Module: alu_drv

Interface
REQ-001 Parameter ALU_LAT, default 1, sets the ALU32 clock-to-result latency in cycles; legal range 1..4.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_sel  input  3  ALU operation select, passed through opaquely.
REQ-007 req_a, req_b  input  32 each  ALU operands.
REQ-008 req_cin  input  1  ALU carry-in.
REQ-009 req_exp_sum  input  32  expected Sum (checker only).
REQ-010 req_exp_cout  input  1  expected Cout (checker only).
REQ-011 alu_sel  output  3, alu_a / alu_b  output  32, alu_cin  output  1: registered drive into ALU32 sel/A/B/Cin.
REQ-012 alu_sum  input  32, alu_cout  input  1: ALU32 Sum/Cout.
REQ-013 rsp_valid  output  1  captured result available.
REQ-014 rsp_ready  input  1  consumer accepts result.
REQ-015 rsp_sum  output  32, rsp_cout  output  1: captured result.
REQ-016 rsp_mismatch  output  1  captured result differs from expected.
REQ-017 err_count  output  16  saturating mismatch counter.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, HOLD, RESP; one request in flight at a time.
REQ-020 req_ready SHALL equal (state==IDLE); request accepted on an edge where req_valid and req_ready are both high.
REQ-021 On accept: latch req_sel/a/b/cin into alu_* registers and latch expected values; IDLE->HOLD; clear latency counter.
REQ-022 alu_* SHALL stay stable from the accept edge until the next accept; no change in HOLD or RESP.
REQ-023 In HOLD counter increments each cycle; at the edge ALU_LAT+1 edges after the accept edge, capture alu_sum/alu_cout into rsp_sum/rsp_cout, HOLD->RESP.
REQ-024 Accept-to-rsp_valid latency SHALL be exactly ALU_LAT+1 cycles (2 cycles at ALU_LAT=1).
REQ-025 rsp_valid SHALL equal (state==RESP); rsp_sum/rsp_cout/rsp_mismatch SHALL hold stable while rsp_valid and not rsp_ready.
REQ-026 RESP->IDLE on edge with rsp_ready high; no new request accepted on that same edge (req_ready low in RESP).
REQ-027 req_valid in HOLD/RESP SHALL be ignored and not queued.
REQ-028 Width rule: outputs are captured verbatim, no sign/zero extension or modification; carry semantics belong to ALU32.

Reset
REQ-029 rst high on an edge SHALL force IDLE, alu_* = 0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_mismatch=0, err_count=0, busy=0.
REQ-030 Reset in HOLD or RESP SHALL abandon the operation with no response and no err_count update; rst has priority over all events on the same edge.

Configuration
REQ-031 Macro ALU_DRV_CHECK_EN defined: on capture rsp_mismatch = (alu_sum!=exp_sum)||(alu_cout!=exp_cout); err_count increments by 1 on each mismatching capture, saturating at 16'hFFFF.
REQ-032 ALU_DRV_CHECK_EN undefined: rsp_mismatch and err_count tied to 0, req_exp_* ignored, no compare logic synthesised; all other behaviour identical.

Verification
REQ-033 ALU_LAT=1, sel=000 A=1 B=1 Cin=0, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rsp_sum=2, rsp_cout per ALU32, busy high 3 cycles.
REQ-034 sel=000 A=32'hFFFFFFFF B=1 Cin=0 -> rsp_sum=0 and rsp_cout as produced by ALU32, captured unchanged.
REQ-035 rsp_ready low 5 cycles after rsp_valid, req_valid held high with new operands -> rsp_* stable, req_ready low, alu_* unchanged, second request accepted only in the cycle after the rsp handshake.
REQ-036 CHECK_EN: sel=100 A=5 B=3 with exp_sum=5 mismatching the ALU32 result -> rsp_mismatch=1, err_count=1; next op with correct expectation -> rsp_mismatch=0, err_count stays 1.
REQ-037 rst asserted one cycle into HOLD -> next cycle IDLE, req_ready=1, rsp_valid never asserted, alu_*=0, err_count=0.
REQ-038 Force err_count to 16'hFFFE via 2 further mismatches -> reads 16'hFFFF and stays there.
